// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and stall control for the
// IF -> irbuffer1 -> EX -> irbuffer2 -> MW pipeline. A private scoreboard
// tracks what sits in MW and write-back so EX operands can be forwarded,
// load-use hazards bubbled and data-memory waits frozen.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ex_instr,
  input  logic             br_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             buf1_en,
  output logic             buf1_flush,
  output logic             buf2_en,
  output logic             buf2_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_wait,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_OP   = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic {RUN, WAIT} state_t;

  state_t     state, state_nx;
  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic       uses_rs1, uses_rs2, writes_rd, is_load, is_mem;

  // scoreboard entries for the MW and write-back stages
  logic       mw_vw, mw_ld, mw_mem;
  logic [4:0] mw_rd;
  logic       wb_vw;
  logic [4:0] wb_rd;

  logic       mem_stall, lu, lu1, lu2;

  // funct3/funct7 fields play no part in hazard detection
  logic       unused_fields;
  assign unused_fields = ^{ex_instr[31:25], ex_instr[14:12]};

  assign opc = ex_instr[6:0];
  assign rd  = ex_instr[11:7];
  assign rs1 = ex_instr[19:15];
  assign rs2 = ex_instr[24:20];

  // decode register usage of the instruction in EX; unknown opcodes use nothing
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_mem    = 1'b0;
    case (opc)
      OP_OP:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      OP_IMM:  begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_LD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; is_mem = 1'b1; end
      OP_ST:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_mem = 1'b1; end
      OP_BR:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_LUI:  writes_rd = 1'b1;
      OP_AUI:  writes_rd = 1'b1;
      OP_JAL:  writes_rd = 1'b1;
      OP_JALR: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      default: ;
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  // scoreboard advances only when irbuffer2 loads; a bubble enters MW as all zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_vw  <= 1'b0;
      mw_rd  <= 5'd0;
      mw_ld  <= 1'b0;
      mw_mem <= 1'b0;
      wb_vw  <= 1'b0;
      wb_rd  <= 5'd0;
    end else if (buf2_en) begin
      wb_vw <= mw_vw;
      wb_rd <= mw_rd;
      if (buf2_bubble) begin
        mw_vw  <= 1'b0;
        mw_rd  <= 5'd0;
        mw_ld  <= 1'b0;
        mw_mem <= 1'b0;
      end else begin
        mw_vw  <= writes_rd;
        mw_rd  <= rd;
        mw_ld  <= is_load;
        mw_mem <= is_mem;
      end
    end
  end

  // operand forwarding: a non-load MW result wins over write-back data
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (uses_rs1 && rs1 != 5'd0) begin
      if (mw_vw && mw_rd == rs1 && !mw_ld) fwd_a = 2'b01;
      else if (wb_vw && wb_rd == rs1)      fwd_a = 2'b10;
    end
    if (uses_rs2 && rs2 != 5'd0) begin
      if (mw_vw && mw_rd == rs2 && !mw_ld) fwd_b = 2'b01;
      else if (wb_vw && wb_rd == rs2)      fwd_b = 2'b10;
    end
  end

  assign lu1 = uses_rs1 && rs1 != 5'd0 && mw_rd == rs1;
  assign lu2 = uses_rs2 && rs2 != 5'd0 && mw_rd == rs2;
  assign lu  = mw_vw && mw_ld && (lu1 || lu2);

  // the access in MW stalls everything until the memory answers
  assign mem_stall = !dmem_ready && (state == WAIT || mw_mem);
  assign mem_wait  = (state == WAIT);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // next state and pipeline controls: memory stall > load-use > taken branch
  always_comb begin
    state_nx    = state;
    pc_en       = 1'b1;
    buf1_en     = 1'b1;
    buf1_flush  = 1'b0;
    buf2_en     = 1'b1;
    buf2_bubble = 1'b0;
    case (state)
      RUN:  if (mw_mem && !dmem_ready) state_nx = WAIT;
      WAIT: if (dmem_ready)            state_nx = RUN;
      default: state_nx = RUN;
    endcase
    if (mem_stall) begin
      pc_en   = 1'b0;
      buf1_en = 1'b0;
      buf2_en = 1'b0;
    end else if (lu) begin
      pc_en       = 1'b0;
      buf1_en     = 1'b0;
      buf2_bubble = 1'b1;
    end else if (br_taken && !rst) begin
      buf1_flush = 1'b1;
    end
  end

  // saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((mem_stall || lu) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (buf1_flush && flush_cnt != '1)        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
    ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111, AUI = 7'b0010111,
    JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_instr;
  logic        br_taken, dmem_ready;
  logic        pc_en, buf1_en, buf1_flush, buf2_en, buf2_bubble, mem_wait;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic        q_pc_en, q_buf1_en, q_buf1_flush, q_buf2_en, q_buf2_bubble, q_mem_wait;
  logic [1:0]  q_fwd_a, q_fwd_b;
  logic [3:0]  q_stall_cnt, q_flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_instr(ex_instr), .br_taken(br_taken),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .buf1_en(buf1_en),
    .buf1_flush(buf1_flush), .buf2_en(buf2_en), .buf2_bubble(buf2_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_wait(mem_wait),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ex_instr(ex_instr), .br_taken(br_taken),
    .dmem_ready(dmem_ready), .pc_en(q_pc_en), .buf1_en(q_buf1_en),
    .buf1_flush(q_buf1_flush), .buf2_en(q_buf2_en), .buf2_bubble(q_buf2_bubble),
    .fwd_a(q_fwd_a), .fwd_b(q_fwd_b), .mem_wait(q_mem_wait),
    .stall_cnt(q_stall_cnt), .flush_cnt(q_flush_cnt));

  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [4:0] s1, logic [4:0] s2);
    return {7'd0, s2, s1, 3'd0, rd, op};
  endfunction

  // ---- reference model: the actual instruction words sitting in MW and WB ----
  function automatic bit m_use1(logic [31:0] i);
    return i[6:0] inside {OP, OPI, LD, ST, BR, JALR};
  endfunction
  function automatic bit m_use2(logic [31:0] i);
    return i[6:0] inside {OP, ST, BR};
  endfunction
  function automatic bit m_wr(logic [31:0] i);
    return (i[6:0] inside {OP, OPI, LD, LUI, AUI, JAL, JALR}) && i[11:7] != 0;
  endfunction
  function automatic bit m_mem(logic [31:0] i);
    return i[6:0] == LD || i[6:0] == ST;
  endfunction
  function automatic logic [1:0] m_src(logic [31:0] mw, logic [31:0] wb, logic [4:0] r, bit used);
    if (!used || r == 0) return 2'b00;
    if (m_wr(mw) && mw[11:7] == r && mw[6:0] != LD) return 2'b01;
    if (m_wr(wb) && wb[11:7] == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive(logic [31:0] e, logic b, logic r);
    ex_instr = e; br_taken = b; dmem_ready = r;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_instr = NOP; br_taken = 1'b0; dmem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_instr = mk(OP, 3, 1, 2); br_taken = 1'b1; dmem_ready = 1'b0;
    #1;
    total++;
    if ({pc_en, buf1_en, buf2_en, buf1_flush, buf2_bubble, mem_wait, fwd_a, fwd_b} !== 10'b1110000000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", {pc_en, buf1_en, buf2_en, buf1_flush, buf2_bubble, mem_wait, fwd_a, fwd_b}, 10'b1110000000);
    end
    total++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    drive(mk(OP, 5, 1, 2), 0, 1); adv();
    drive(mk(OP, 6, 5, 5), 0, 1);
    total++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01 || pc_en !== 1'b1) begin
      bad++;
      $display("FAIL fwd_mw got=%b/%b pc_en=%b exp=01/01 pc_en=1", fwd_a, fwd_b, pc_en);
    end
    do_reset();
    drive(mk(OP, 5, 1, 2), 0, 1); adv();
    drive(mk(OPI, 10, 0, 0), 0, 1); adv();
    drive(mk(OP, 6, 5, 5), 0, 1);
    total++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      bad++;
      $display("FAIL fwd_wb got=%b/%b exp=10/10", fwd_a, fwd_b);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(mk(LD, 7, 1, 0), 0, 1); adv();
    drive(mk(OP, 8, 7, 1), 1, 1);
    total++;
    if ({pc_en, buf1_en, buf2_en, buf2_bubble, buf1_flush} !== 5'b00110) begin
      bad++;
      $display("FAIL lu_stall got=%b exp=00110", {pc_en, buf1_en, buf2_en, buf2_bubble, buf1_flush});
    end
    adv();
    drive(mk(OP, 8, 7, 1), 0, 1);
    total++;
    if (pc_en !== 1'b1 || buf2_bubble !== 1'b0 || fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      bad++;
      $display("FAIL lu_after got pc_en=%b bub=%b fwd=%b/%b exp 1 0 10/00", pc_en, buf2_bubble, fwd_a, fwd_b);
    end
    total++;
    if (stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL lu_cnt got=%0d exp=1", stall_cnt);
    end
  endtask

  task automatic test_x0_nouse();
    do_reset();
    drive(mk(LD, 0, 1, 0), 0, 1); adv();
    drive(mk(OP, 8, 0, 0), 0, 1);
    total++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || pc_en !== 1'b1) begin
      bad++;
      $display("FAIL x0_load got=%b/%b pc_en=%b exp=00/00 1", fwd_a, fwd_b, pc_en);
    end
    do_reset();
    drive(mk(LD, 9, 1, 0), 0, 1); adv();
    drive(mk(LUI, 3, 9, 9), 0, 1);
    total++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || pc_en !== 1'b1) begin
      bad++;
      $display("FAIL lui_nouse got=%b/%b pc_en=%b exp=00/00 1", fwd_a, fwd_b, pc_en);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(mk(OP, 1, 2, 3), 1, 1);
    total++;
    if ({pc_en, buf1_en, buf2_en, buf1_flush, buf2_bubble} !== 5'b11110) begin
      bad++;
      $display("FAIL br_flush got=%b exp=11110", {pc_en, buf1_en, buf2_en, buf1_flush, buf2_bubble});
    end
    adv();
    drive(NOP, 0, 1);
    total++;
    if (buf1_flush !== 1'b0 || flush_cnt !== 16'd1) begin
      bad++;
      $display("FAIL br_after got flush=%b cnt=%0d exp 0 1", buf1_flush, flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    int waits = 0;
    do_reset();
    drive(mk(ST, 0, 2, 1), 0, 1); adv();
    for (int k = 0; k < 3; k++) begin
      drive(mk(OP, 4, 1, 2), 1, 0);
      total++;
      if ({pc_en, buf1_en, buf2_en, buf1_flush, buf2_bubble} !== 5'b00000) begin
        bad++;
        $display("FAIL mw_stall k=%0d got=%b exp=00000", k, {pc_en, buf1_en, buf2_en, buf1_flush, buf2_bubble});
      end
      if (mem_wait) waits++;
      adv();
    end
    drive(mk(OP, 4, 1, 2), 1, 1);
    if (mem_wait) waits++;
    total++;
    if (pc_en !== 1'b1 || buf1_flush !== 1'b1 || stall_cnt !== 16'd3 || flush_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mw_release got pc_en=%b flush=%b st=%0d fl=%0d exp 1 1 3 0", pc_en, buf1_flush, stall_cnt, flush_cnt);
    end
    adv();
    drive(NOP, 0, 1);
    if (mem_wait) waits++;
    total++;
    if (waits !== 3 || flush_cnt !== 16'd1) begin
      bad++;
      $display("FAIL mw_count got waits=%0d fl=%0d exp 3 1", waits, flush_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(mk(ST, 0, 2, 1), 0, 1); adv();
    drive(mk(OP, 4, 1, 2), 1, 0); adv();
    drive(mk(OP, 4, 1, 2), 1, 0);
    total++;
    if (mem_wait !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got mem_wait=%b exp 1", mem_wait);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({pc_en, buf1_en, buf2_en, buf1_flush, buf2_bubble, mem_wait, fwd_a, fwd_b} !== 10'b1110000000 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid got=%b st=%0d exp=1110000000 0", {pc_en, buf1_en, buf2_en, buf1_flush, buf2_bubble, mem_wait, fwd_a, fwd_b}, stall_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(mk(LD, 7, 1, 0), 0, 1); adv();
      drive(mk(OP, 8, 7, 1), 0, 1); adv();
      drive(mk(OP, 8, 7, 1), 0, 1); adv();
    end
    drive(NOP, 0, 1);
    total++;
    if (q_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
      bad++;
      $display("FAIL sat got=%0d/%0d exp=15/20", q_stall_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] m_mw = NOP, m_wb = NOP, e;
    bit m_wait = 0, mst, lu, b, r, exp_b2, exp_bub;
    int m_st = 0, m_fl = 0;
    logic [6:0] ops [10] = '{OP, OPI, LD, ST, BR, LUI, AUI, JAL, JALR, 7'b1111111};
    logic [9:0] exp_v, got_v;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      e = mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      b = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) != 0);
      drive(e, b, r);
      mst = !r && (m_wait || m_mem(m_mw));
      lu  = m_wr(m_mw) && m_mw[6:0] == LD &&
            ((m_use1(e) && e[19:15] != 0 && e[19:15] == m_mw[11:7]) ||
             (m_use2(e) && e[24:20] != 0 && e[24:20] == m_mw[11:7]));
      exp_b2  = !mst;
      exp_bub = !mst && lu;
      exp_v = {!mst && !lu, !mst && !lu, !mst && !lu && b, exp_b2, exp_bub, m_wait,
               m_src(m_mw, m_wb, e[19:15], m_use1(e)), m_src(m_mw, m_wb, e[24:20], m_use2(e))};
      got_v = {pc_en, buf1_en, buf1_flush, buf2_en, buf2_bubble, mem_wait, fwd_a, fwd_b};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL rand_ctrl cyc=%0d instr=%h got=%b exp=%b", c, e, got_v, exp_v);
      end
      total++;
      if (stall_cnt !== 16'(m_st) || flush_cnt !== 16'(m_fl) || q_stall_cnt !== 4'(m_st > 15 ? 15 : m_st)) begin
        bad++;
        $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d", c, stall_cnt, flush_cnt, q_stall_cnt, m_st, m_fl);
      end
      adv();
      if (mst || lu) m_st++;
      if (exp_v[7]) m_fl++;
      if (exp_b2) begin
        m_wb = m_mw;
        m_mw = exp_bub ? NOP : e;
      end
      m_wait = mst;
    end
  endtask

  initial begin
    rst = 1'b1; ex_instr = NOP; br_taken = 1'b0; dmem_ready = 1'b1;
    test_reset();
    test_forward();
    test_load_use();
    test_x0_nouse();
    test_branch();
    test_mem_wait();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
